// File: rtl/m_74ls161_pkg.sv
// Shared definitions for the counter library: default width, terminal count
// and the per-edge operating mode handed to each bit stage.
package m_74ls161_pkg;

  localparam int CNT_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] CNT_TERMINAL = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_LOAD  = 2'd1,
    MODE_COUNT = 2'd2
  } cnt_mode_e;

endpackage

// File: rtl/m_161_bit_stage.sv
// One counter bit: a flop with asynchronous clear fed by a load/toggle/hold mux.
import m_74ls161_pkg::*;

module m_161_bit_stage (
  input  logic      CP,
  input  logic      CR,
  input  cnt_mode_e mode,
  input  logic      d,
  input  logic      lower_ones,
  output logic      q
);

  // In count mode a bit toggles only when every lower bit is already 1.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      q <= 1'b0;
    end else begin
      case (mode)
        MODE_LOAD:  q <= d;
        MODE_COUNT: q <= lower_ones ? ~q : q;
        default:    q <= q;
      endcase
    end
  end

endmodule

// File: rtl/m_74ls161.sv
// 74LS161-style synchronous binary counter: async clear, sync load,
// dual count enables and a combinational ripple-carry for cascading.
import m_74ls161_pkg::*;

module m_74ls161 #(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             CR,
  input  logic             LD,
  input  logic             CT_P,
  input  logic             CT_T,
  input  logic             CP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO
);

  cnt_mode_e        mode;
  logic [WIDTH:0]   lower_ones;

  // Load has priority over counting; clear is handled inside each stage.
  always_comb begin
    mode = MODE_HOLD;
    if (!LD) begin
      mode = MODE_LOAD;
    end else if (CT_P && CT_T) begin
      mode = MODE_COUNT;
    end
  end

  // lower_ones[i] is the AND of Q[i-1:0]; the top entry marks terminal count.
  assign lower_ones[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage
      assign lower_ones[i+1] = lower_ones[i] & Q[i];

      m_161_bit_stage u_stage (
        .CP         (CP),
        .CR         (CR),
        .mode       (mode),
        .d          (D[i]),
        .lower_ones (lower_ones[i]),
        .q          (Q[i])
      );
    end
  endgenerate

  assign CO = CT_T & lower_ones[WIDTH];

endmodule

// File: tb/tb_m_74ls161.sv
// Randomised and directed bench for m_74ls161 with a queue-based scoreboard.
import m_74ls161_pkg::*;

module tb_m_74ls161;

  logic       cp = 1'b0;
  logic       cr = 1'b1;
  logic       ld = 1'b1;
  logic       ct_p = 1'b0;
  logic       ct_t = 1'b0;
  logic [3:0] d = 4'd0;
  logic [3:0] q;
  logic       co;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       co;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;
  int   mq = 0;

  m_74ls161 #(.WIDTH(4)) dut (
    .CR   (cr),
    .LD   (ld),
    .CT_P (ct_p),
    .CT_T (ct_t),
    .CP   (cp),
    .D    (d),
    .Q    (q),
    .CO   (co)
  );

  always #5 cp = ~cp;

  task automatic push_expect(input string nm, input int eq, input logic eco);
    exp_t e;
    e.name = nm;
    e.q    = 4'(eq);
    e.co   = eco;
    sb_q.push_back(e);
    ->sample_ev;
  endtask

  // Drive one clock's worth of inputs and predict the state after the edge.
  task automatic step(input string nm, input logic cr_i, input logic ld_i,
                      input logic p_i, input logic t_i, input logic [3:0] d_i);
    @(negedge cp);
    cr = cr_i; ld = ld_i; ct_p = p_i; ct_t = t_i; d = d_i;
    if (cr_i)              mq = 0;
    else if (!ld_i)        mq = int'(d_i);
    else if (p_i && t_i)   mq = (mq + 1) % 16;
    @(posedge cp);
    #1;
    push_expect(nm, mq, t_i && !cr_i && (mq == int'(CNT_TERMINAL)));
  endtask

  // Monitor: compares the DUT against the oldest expectation on each sample.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: sample with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (q !== e.q) begin
          errors++;
          $display("FAIL %s Q: got %0d expected %0d", e.name, q, e.q);
        end
        checks++;
        if (co !== e.co) begin
          errors++;
          $display("FAIL %s CO: got %0b expected %0b", e.name, co, e.co);
        end
      end
    end
  end

  initial begin
    logic r_cr, r_ld, r_p, r_t;
    logic [3:0] r_d;

    #3;
    push_expect("reset", 0, 1'b0);
    step("reset_hold", 1'b1, 1'b1, 1'b1, 1'b1, 4'd7);

    // Async clear while counting at 9, then release and count from 0.
    step("load8",  1'b0, 1'b0, 1'b0, 1'b0, 4'd8);
    step("count9", 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    #2 cr = 1'b1;
    #1;
    mq = 0;
    push_expect("async_clear", 0, 1'b0);
    #19 cr = 1'b0;
    step("release_count", 1'b0, 1'b1, 1'b1, 1'b1, 4'd0);

    step("load12",        1'b0, 1'b0, 1'b0, 1'b0, 4'b1100);
    step("load12_en",     1'b0, 1'b0, 1'b1, 1'b1, 4'b1100);
    step("load12_en2",    1'b0, 1'b0, 1'b1, 1'b1, 4'b1100);
    step("count13",       1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    step("count14",       1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    step("count15",       1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    step("wrap0",         1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    step("count1",        1'b0, 1'b1, 1'b1, 1'b1, 4'd0);

    step("load15",        1'b0, 1'b0, 1'b0, 1'b0, 4'd15);
    step("hold_p0",       1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    step("hold_t0",       1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    step("hold_t1",       1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
    step("load_on_wrap",  1'b0, 1'b0, 1'b1, 1'b1, 4'b0101);
    step("clear_over_ld", 1'b1, 1'b0, 1'b1, 1'b1, 4'd9);
    step("after_clear",   1'b0, 1'b1, 1'b1, 1'b1, 4'd9);

    for (int n = 0; n < 400; n++) begin
      r_cr = ($urandom_range(0, 15) == 0);
      r_ld = ($urandom_range(0, 3) != 0);
      r_p  = ($urandom_range(0, 3) != 0);
      r_t  = ($urandom_range(0, 3) != 0);
      r_d  = 4'($urandom);
      step("random", r_cr, r_ld, r_p, r_t, r_d);
    end

    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
